// File: rtl/armleocpu_mmu_pkg.sv
// ============================================================================
// Module      : armleocpu_mmu_pkg
// Description : Shared widths, PTE bit positions and walker states for the MMU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package armleocpu_mmu_pkg;

    localparam int PHYS_W = 22;
    localparam int VPN_W  = 20;
    localparam int TAG_W  = 8;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    // Bare mode grants D A - - X W R V so the requester sees a fully permitted page
    localparam logic [TAG_W-1:0] BARE_TAG = 8'hCF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLUSH   = 3'd1,
        LOOKUP  = 3'd2,
        PTE1    = 3'd3,
        PTE0    = 3'd4,
        REFILL  = 3'd5,
        RESPOND = 3'd6
    } ptw_state_t;

endpackage

`default_nettype wire

// File: rtl/armleocpu_ptw_pte_check.sv
// ============================================================================
// Module      : armleocpu_ptw_pte_check
// Description : Combinational Sv32 PTE validity/leaf decode and PPN formation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module armleocpu_ptw_pte_check
    import armleocpu_mmu_pkg::*;
(
    input  logic [31:0]       pte_i,
    input  logic              level_i,
    input  logic [9:0]        vpn_lo_i,
    input  logic              mem_error_i,
    output logic              fault_o,
    output logic              leaf_o,
    output logic [PHYS_W-1:0] phys_o
);

    logic w_leaf;
    logic w_misaligned;

    always_comb begin
        w_leaf       = pte_i[PTE_R] | pte_i[PTE_X];
        // A megapage must not carry low PPN bits
        w_misaligned = level_i & w_leaf & (|pte_i[19:10]);
        fault_o      = mem_error_i
                     | ~pte_i[PTE_V]
                     | (~pte_i[PTE_R] & pte_i[PTE_W])
                     | (~w_leaf & ~level_i)
                     | w_misaligned;
        leaf_o       = w_leaf;
        phys_o       = level_i ? {pte_i[31:20], vpn_lo_i} : pte_i[31:10];
    end

endmodule

`default_nettype wire

// File: rtl/armleocpu_ptw.sv
// ============================================================================
// Module      : armleocpu_ptw
// Description : Sv32 page-table walker sequencing TLB lookup, refill and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module armleocpu_ptw
    import armleocpu_mmu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [VPN_W-1:0]  req_vpn,
    input  logic              flush,
    input  logic              satp_mode,
    input  logic [PHYS_W-1:0] satp_ppn,
    output logic              resp_done,
    output logic              resp_fault,
    output logic [TAG_W-1:0]  resp_accesstag,
    output logic [PHYS_W-1:0] resp_phys,
    output logic              flush_done,
    output logic              tlb_enable,
    output logic              tlb_resolve,
    output logic              tlb_invalidate,
    output logic              tlb_write,
    output logic [VPN_W-1:0]  tlb_virtual_address,
    input  logic              tlb_miss,
    input  logic              tlb_done,
    input  logic [TAG_W-1:0]  tlb_accesstag_r,
    input  logic [PHYS_W-1:0] tlb_phys_r,
    output logic [VPN_W-1:0]  tlb_virtual_address_w,
    output logic [TAG_W-1:0]  tlb_accesstag_w,
    output logic [PHYS_W-1:0] tlb_phys_w,
    output logic              mem_read,
    output logic [33:0]       mem_address,
    input  logic              mem_done,
    input  logic              mem_error,
    input  logic [31:0]       mem_rdata
);

    ptw_state_t        state_q, state_d;
    logic              resp_done_q, resp_done_d;
    logic              resp_fault_q, resp_fault_d;
    logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
    logic [PHYS_W-1:0] resp_phys_q, resp_phys_d;
    logic              flush_done_q, flush_done_d;
    logic              tlb_enable_q, tlb_enable_d;
    logic              tlb_resolve_q, tlb_resolve_d;
    logic              tlb_invalidate_q, tlb_invalidate_d;
    logic              tlb_write_q, tlb_write_d;
    logic [VPN_W-1:0]  vpn_q, vpn_d;
    logic [TAG_W-1:0]  tag_w_q, tag_w_d;
    logic [PHYS_W-1:0] phys_w_q, phys_w_d;
    logic              mem_read_q, mem_read_d;
    logic [33:0]       mem_addr_q, mem_addr_d;

    logic              w_fault;
    logic              w_leaf;
    logic [PHYS_W-1:0] w_phys;

    armleocpu_ptw_pte_check u_pte_check (
        .pte_i       (mem_rdata),
        .level_i     (state_q == PTE1),
        .vpn_lo_i    (vpn_q[9:0]),
        .mem_error_i (mem_error),
        .fault_o     (w_fault),
        .leaf_o      (w_leaf),
        .phys_o      (w_phys)
    );

    always_comb begin
        state_d          = state_q;
        resp_done_d      = 1'b0;
        flush_done_d     = 1'b0;
        tlb_enable_d     = 1'b0;
        tlb_resolve_d    = 1'b0;
        tlb_invalidate_d = 1'b0;
        tlb_write_d      = 1'b0;
        mem_read_d       = 1'b0;
        resp_fault_d     = resp_fault_q;
        resp_tag_d       = resp_tag_q;
        resp_phys_d      = resp_phys_q;
        vpn_d            = vpn_q;
        tag_w_d          = tag_w_q;
        phys_w_d         = phys_w_q;
        mem_addr_d       = mem_addr_q;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d          = FLUSH;
                    tlb_invalidate_d = 1'b1;
                end else if (req && !satp_mode) begin
                    state_d      = RESPOND;
                    resp_done_d  = 1'b1;
                    resp_fault_d = 1'b0;
                    resp_tag_d   = BARE_TAG;
                    resp_phys_d  = {2'b00, req_vpn};
                end else if (req) begin
                    state_d       = LOOKUP;
                    tlb_enable_d  = 1'b1;
                    tlb_resolve_d = 1'b1;
                    vpn_d         = req_vpn;
                end
            end
            // RESPOND doubles as the pulse cycle for flush_done, keeping a held flush out of IDLE
            FLUSH: begin
                state_d      = RESPOND;
                flush_done_d = 1'b1;
            end
            LOOKUP: begin
                if (tlb_done && !tlb_miss) begin
                    state_d      = RESPOND;
                    resp_done_d  = 1'b1;
                    resp_fault_d = 1'b0;
                    resp_tag_d   = tlb_accesstag_r;
                    resp_phys_d  = tlb_phys_r;
                end else if (tlb_done) begin
                    state_d    = PTE1;
                    mem_read_d = 1'b1;
                    mem_addr_d = {satp_ppn, vpn_q[19:10], 2'b00};
                end else begin
                    tlb_enable_d  = 1'b1;
                    tlb_resolve_d = 1'b1;
                end
            end
            PTE1, PTE0: begin
                if (!mem_done) begin
                    mem_read_d = 1'b1;
                end else if (w_fault) begin
                    state_d      = RESPOND;
                    resp_done_d  = 1'b1;
                    resp_fault_d = 1'b1;
                    resp_tag_d   = '0;
                    resp_phys_d  = '0;
                end else if (w_leaf) begin
                    state_d     = REFILL;
                    tlb_write_d = 1'b1;
                    tag_w_d     = mem_rdata[7:0];
                    phys_w_d    = w_phys;
                end else begin
                    // Only reachable from PTE1: a pointer at PTE0 decodes as a fault
                    state_d    = PTE0;
                    mem_read_d = 1'b1;
                    mem_addr_d = {mem_rdata[31:10], vpn_q[9:0], 2'b00};
                end
            end
            REFILL: begin
                state_d      = RESPOND;
                resp_done_d  = 1'b1;
                resp_fault_d = 1'b0;
                resp_tag_d   = tag_w_q;
                resp_phys_d  = phys_w_q;
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            resp_done_q      <= 1'b0;
            resp_fault_q     <= 1'b0;
            resp_tag_q       <= '0;
            resp_phys_q      <= '0;
            flush_done_q     <= 1'b0;
            tlb_enable_q     <= 1'b0;
            tlb_resolve_q    <= 1'b0;
            tlb_invalidate_q <= 1'b0;
            tlb_write_q      <= 1'b0;
            vpn_q            <= '0;
            tag_w_q          <= '0;
            phys_w_q         <= '0;
            mem_read_q       <= 1'b0;
            mem_addr_q       <= '0;
        end else begin
            state_q          <= state_d;
            resp_done_q      <= resp_done_d;
            resp_fault_q     <= resp_fault_d;
            resp_tag_q       <= resp_tag_d;
            resp_phys_q      <= resp_phys_d;
            flush_done_q     <= flush_done_d;
            tlb_enable_q     <= tlb_enable_d;
            tlb_resolve_q    <= tlb_resolve_d;
            tlb_invalidate_q <= tlb_invalidate_d;
            tlb_write_q      <= tlb_write_d;
            vpn_q            <= vpn_d;
            tag_w_q          <= tag_w_d;
            phys_w_q         <= phys_w_d;
            mem_read_q       <= mem_read_d;
            mem_addr_q       <= mem_addr_d;
        end
    end

    assign resp_done             = resp_done_q;
    assign resp_fault            = resp_fault_q;
    assign resp_accesstag        = resp_tag_q;
    assign resp_phys             = resp_phys_q;
    assign flush_done            = flush_done_q;
    assign tlb_enable            = tlb_enable_q;
    assign tlb_resolve           = tlb_resolve_q;
    assign tlb_invalidate        = tlb_invalidate_q;
    assign tlb_write             = tlb_write_q;
    assign tlb_virtual_address   = vpn_q;
    assign tlb_virtual_address_w = vpn_q;
    assign tlb_accesstag_w       = tag_w_q;
    assign tlb_phys_w            = phys_w_q;
    assign mem_read              = mem_read_q;
    assign mem_address           = mem_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_armleocpu_ptw.sv
// ============================================================================
// Module      : tb_armleocpu_ptw
// Description : Scenario bench for the Sv32 walker with TLB and memory models.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_armleocpu_ptw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [19:0] req_vpn;
    logic        flush;
    logic        satp_mode;
    logic [21:0] satp_ppn;
    logic        resp_done, resp_fault, flush_done;
    logic [7:0]  resp_accesstag;
    logic [21:0] resp_phys;
    logic        tlb_enable, tlb_resolve, tlb_invalidate, tlb_write;
    logic [19:0] tlb_virtual_address, tlb_virtual_address_w;
    logic        tlb_miss, tlb_done;
    logic [7:0]  tlb_accesstag_r, tlb_accesstag_w;
    logic [21:0] tlb_phys_r, tlb_phys_w;
    logic        mem_read, mem_done, mem_error;
    logic [33:0] mem_address;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    armleocpu_ptw dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_vpn(req_vpn), .flush(flush),
        .satp_mode(satp_mode), .satp_ppn(satp_ppn),
        .resp_done(resp_done), .resp_fault(resp_fault), .resp_accesstag(resp_accesstag),
        .resp_phys(resp_phys), .flush_done(flush_done),
        .tlb_enable(tlb_enable), .tlb_resolve(tlb_resolve), .tlb_invalidate(tlb_invalidate),
        .tlb_write(tlb_write), .tlb_virtual_address(tlb_virtual_address),
        .tlb_miss(tlb_miss), .tlb_done(tlb_done), .tlb_accesstag_r(tlb_accesstag_r),
        .tlb_phys_r(tlb_phys_r), .tlb_virtual_address_w(tlb_virtual_address_w),
        .tlb_accesstag_w(tlb_accesstag_w), .tlb_phys_w(tlb_phys_w),
        .mem_read(mem_read), .mem_address(mem_address), .mem_done(mem_done),
        .mem_error(mem_error), .mem_rdata(mem_rdata)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        fault;
        logic [7:0]  tag;
        logic [21:0] phys;
        int          lat;
    } exp_t;
    exp_t sb[$];

    // ---------------- TLB model: 4 entries, round-robin refill ----------------
    logic        tv[4];
    logic [19:0] tvpn[4];
    logic [7:0]  ttag[4];
    logic [21:0] tphys[4];
    logic [1:0]  tptr;
    logic        tlb_clr = 1'b0;
    logic        pre_load = 1'b0;
    logic [19:0] pre_vpn = '0;
    logic [7:0]  pre_tag = '0;
    logic [21:0] pre_phys = '0;
    logic        t_hit;
    logic [1:0]  t_idx;

    always_comb begin
        t_hit = 1'b0;
        t_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (tv[i] && tvpn[i] == tlb_virtual_address) begin
                t_hit = 1'b1;
                t_idx = i[1:0];
            end
        end
    end

    always @(posedge clk) begin
        tlb_done        <= tlb_enable && tlb_resolve;
        tlb_miss        <= !t_hit;
        tlb_accesstag_r <= t_hit ? ttag[t_idx] : 8'h00;
        tlb_phys_r      <= t_hit ? tphys[t_idx] : 22'h0;
        if (tlb_clr || tlb_invalidate) begin
            for (int i = 0; i < 4; i++) tv[i] <= 1'b0;
            if (tlb_clr) tptr <= 2'd0;
        end else if (tlb_write) begin
            tv[tptr] <= 1'b1; tvpn[tptr] <= tlb_virtual_address_w;
            ttag[tptr] <= tlb_accesstag_w; tphys[tptr] <= tlb_phys_w;
            tptr <= tptr + 2'd1;
        end else if (pre_load) begin
            tv[tptr] <= 1'b1; tvpn[tptr] <= pre_vpn;
            ttag[tptr] <= pre_tag; tphys[tptr] <= pre_phys;
            tptr <= tptr + 2'd1;
        end
    end

    // ---------------- memory model: small PTE table, configurable wait ----------------
    logic [33:0] maddr[6];
    logic [31:0] mdata[6];
    int          mem_wait = 0;
    int          mcnt;
    logic        err_en = 1'b0;
    logic [33:0] err_addr = '0;

    always_comb begin
        mem_rdata = 32'h0;
        for (int i = 0; i < 6; i++)
            if (maddr[i] == mem_address) mem_rdata = mdata[i];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcnt <= 0;
        else if (mem_read && !mem_done) mcnt <= mcnt + 1;
        else mcnt <= 0;
    end

    assign mem_done  = mem_read && (mcnt >= mem_wait);
    assign mem_error = mem_done && err_en && (mem_address == err_addr);

    int mem_txn = 0;
    int wr_cnt  = 0;
    int inv_cnt = 0;
    always @(negedge clk) begin
        if (mem_read && mem_done) mem_txn <= mem_txn + 1;
        if (tlb_write) wr_cnt <= wr_cnt + 1;
        if (tlb_invalidate) inv_cnt <= inv_cnt + 1;
    end

    // ---------------- drivers ----------------
    task automatic run_req(input logic [19:0] vpn, output int lat, output logic seen);
        req = 1'b1; req_vpn = vpn; lat = 0; seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (resp_done) seen = 1'b1;
        end
        req = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [196:0] outs;
        outs = {resp_done, resp_fault, resp_accesstag, resp_phys, flush_done, tlb_enable,
                tlb_resolve, tlb_invalidate, tlb_write, tlb_virtual_address,
                tlb_virtual_address_w, tlb_accesstag_w, tlb_phys_w, mem_read, mem_address};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
    endtask

    task automatic test_bare();
        exp_t e; int lat; logic seen; int m0, w0;
        m0 = mem_txn; w0 = wr_cnt;
        satp_mode = 1'b0;
        sb.push_back('{fault: 1'b0, tag: 8'hCF, phys: 22'h0ABCDE, lat: 1});
        run_req(20'hABCDE, lat, seen);
        e = sb.pop_front();
        checks++;
        if ({seen, resp_fault, resp_accesstag, resp_phys} !== {1'b1, e.fault, e.tag, e.phys}) begin
            errors++; $display("FAIL bare_resp: got done=%b f=%b tag=%h phys=%h want f=%b tag=%h phys=%h",
                               seen, resp_fault, resp_accesstag, resp_phys, e.fault, e.tag, e.phys);
        end
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL bare_latency: got %0d want %0d", lat, e.lat); end
        @(posedge clk); #1;
        checks++;
        if ((mem_txn - m0) !== 0 || (wr_cnt - w0) !== 0) begin
            errors++; $display("FAIL bare_side_effects: got mem=%0d wr=%0d want 0 0", mem_txn - m0, wr_cnt - w0);
        end
    endtask

    task automatic test_tlb_hit();
        exp_t e; int lat; logic seen; int m0;
        satp_mode = 1'b1; satp_ppn = 22'h100;
        pre_vpn = 20'h12345; pre_tag = 8'h0F; pre_phys = 22'h3F000; pre_load = 1'b1;
        @(posedge clk); #1 pre_load = 1'b0;
        m0 = mem_txn;
        sb.push_back('{fault: 1'b0, tag: 8'h0F, phys: 22'h3F000, lat: 3});
        run_req(20'h12345, lat, seen);
        e = sb.pop_front();
        checks++;
        if ({seen, resp_fault, resp_accesstag, resp_phys} !== {1'b1, e.fault, e.tag, e.phys}) begin
            errors++; $display("FAIL hit_resp: got done=%b f=%b tag=%h phys=%h want f=%b tag=%h phys=%h",
                               seen, resp_fault, resp_accesstag, resp_phys, e.fault, e.tag, e.phys);
        end
        checks++;
        if (lat !== e.lat) begin errors++; $display("FAIL hit_latency: got %0d want %0d", lat, e.lat); end
        @(posedge clk); #1;
        checks++;
        if ((mem_txn - m0) !== 0) begin errors++; $display("FAIL hit_no_mem: got %0d want 0", mem_txn - m0); end
    endtask

    task automatic test_walk();
        exp_t e; int lat; logic seen; int m0, w0;
        mem_wait = 0;
        for (int pass = 0; pass < 2; pass++) begin
            m0 = mem_txn; w0 = wr_cnt;
            sb.push_back('{fault: 1'b0, tag: 8'h0F, phys: 22'h48D0, lat: (pass == 0) ? 6 : 3});
            run_req(20'h00401, lat, seen);
            e = sb.pop_front();
            checks++;
            if ({seen, resp_fault, resp_accesstag, resp_phys} !== {1'b1, e.fault, e.tag, e.phys}) begin
                errors++; $display("FAIL walk_resp[%0d]: got done=%b f=%b tag=%h phys=%h want f=%b tag=%h phys=%h",
                                   pass, seen, resp_fault, resp_accesstag, resp_phys, e.fault, e.tag, e.phys);
            end
            checks++;
            if (lat !== e.lat) begin errors++; $display("FAIL walk_latency[%0d]: got %0d want %0d", pass, lat, e.lat); end
            @(posedge clk); #1;
            checks++;
            if ((mem_txn - m0) !== ((pass == 0) ? 2 : 0) || (wr_cnt - w0) !== ((pass == 0) ? 1 : 0)) begin
                errors++; $display("FAIL walk_counts[%0d]: got mem=%0d wr=%0d", pass, mem_txn - m0, wr_cnt - w0);
            end
        end
    endtask

    task automatic test_megapage();
        exp_t e; int lat; logic seen; int w0;
        logic [19:0] vpns[2];
        vpns[0] = 20'h00C05; vpns[1] = 20'h01005;
        sb.push_back('{fault: 1'b0, tag: 8'h0F, phys: 22'h001005, lat: 5});
        sb.push_back('{fault: 1'b1, tag: 8'h00, phys: 22'h0, lat: 4});
        for (int k = 0; k < 2; k++) begin
            w0 = wr_cnt;
            run_req(vpns[k], lat, seen);
            e = sb.pop_front();
            checks++;
            if ({seen, resp_fault, resp_accesstag, resp_phys, lat} !== {1'b1, e.fault, e.tag, e.phys, e.lat}) begin
                errors++; $display("FAIL mega_resp[%0d]: got f=%b tag=%h phys=%h lat=%0d want f=%b tag=%h phys=%h lat=%0d",
                                   k, resp_fault, resp_accesstag, resp_phys, lat, e.fault, e.tag, e.phys, e.lat);
            end
            @(posedge clk); #1;
            checks++;
            if ((wr_cnt - w0) !== ((k == 0) ? 1 : 0)) begin
                errors++; $display("FAIL mega_writes[%0d]: got %0d want %0d", k, wr_cnt - w0, (k == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic test_faults();
        exp_t e; int lat; logic seen; int w0;
        logic [19:0] vpns[3];
        int lats[3];
        vpns[0] = 20'h00801; vpns[1] = 20'h01401; vpns[2] = 20'h00402;
        lats[0] = 4; lats[1] = 4; lats[2] = 5;
        w0 = wr_cnt;
        err_en = 1'b1; err_addr = 34'h201008;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{fault: 1'b1, tag: 8'h00, phys: 22'h0, lat: lats[k]});
            run_req(vpns[k], lat, seen);
            e = sb.pop_front();
            checks++;
            if ({seen, resp_fault, resp_accesstag, resp_phys, lat} !== {1'b1, e.fault, e.tag, e.phys, e.lat}) begin
                errors++; $display("FAIL fault_resp[%0d]: got f=%b tag=%h phys=%h lat=%0d want f=%b tag=%h phys=%h lat=%0d",
                                   k, resp_fault, resp_accesstag, resp_phys, lat, e.fault, e.tag, e.phys, e.lat);
            end
            @(posedge clk); #1;
        end
        err_en = 1'b0;
        checks++;
        if ((wr_cnt - w0) !== 0) begin errors++; $display("FAIL fault_no_write: got %0d want 0", wr_cnt - w0); end
    endtask

    task automatic test_wait_states();
        exp_t e; int lat; logic seen; logic in_txn; logic [33:0] a0;
        mem_wait = 2;
        sb.push_back('{fault: 1'b0, tag: 8'h0F, phys: 22'h159E0, lat: 10});
        req = 1'b1; req_vpn = 20'h00402; lat = 0; seen = 1'b0; in_txn = 1'b0; a0 = '0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (mem_read) begin
                if (!in_txn) begin
                    in_txn = 1'b1; a0 = mem_address;
                end else begin
                    checks++;
                    if (mem_address !== a0) begin
                        errors++; $display("FAIL wait_addr_stable: got %h want %h", mem_address, a0);
                    end
                end
                if (mem_done) in_txn = 1'b0;
            end
            if (resp_done) seen = 1'b1;
        end
        req = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({seen, resp_fault, resp_accesstag, resp_phys, lat} !== {1'b1, e.fault, e.tag, e.phys, e.lat}) begin
            errors++; $display("FAIL wait_resp: got done=%b f=%b tag=%h phys=%h lat=%0d want f=%b tag=%h phys=%h lat=%0d",
                               seen, resp_fault, resp_accesstag, resp_phys, lat, e.fault, e.tag, e.phys, e.lat);
        end
        mem_wait = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_flush_and_req();
        exp_t e; int n; int inv_at; int fd_at; logic seen; int i0;
        i0 = inv_cnt; inv_at = -1; fd_at = -1; n = 0; seen = 1'b0;
        sb.push_back('{fault: 1'b0, tag: 8'h0F, phys: 22'h48D0, lat: 9});
        flush = 1'b1; req = 1'b1; req_vpn = 20'h00401;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            n++;
            if (tlb_invalidate && inv_at < 0) inv_at = n;
            if (flush_done) begin fd_at = n; flush = 1'b0; end
            if (resp_done) seen = 1'b1;
        end
        req = 1'b0; flush = 1'b0;
        e = sb.pop_front();
        checks++;
        if (inv_at !== 1 || fd_at !== 2) begin
            errors++; $display("FAIL flush_timing: got inv=%0d done=%0d want 1 2", inv_at, fd_at);
        end
        checks++;
        if ({seen, resp_fault, resp_accesstag, resp_phys, n} !== {1'b1, e.fault, e.tag, e.phys, e.lat}) begin
            errors++; $display("FAIL flush_then_walk: got f=%b tag=%h phys=%h lat=%0d want f=%b tag=%h phys=%h lat=%0d",
                               resp_fault, resp_accesstag, resp_phys, n, e.fault, e.tag, e.phys, e.lat);
        end
        @(posedge clk); #1;
        checks++;
        if ((inv_cnt - i0) !== 1) begin errors++; $display("FAIL flush_inv_cycles: got %0d want 1", inv_cnt - i0); end
    endtask

    task automatic test_reset_midwalk();
        exp_t e; int lat; logic seen; logic got_read; int m0; logic [196:0] outs;
        mem_wait = 50; got_read = 1'b0;
        req = 1'b1; req_vpn = 20'h02001;
        for (int i = 0; i < 20 && !got_read; i++) begin
            @(posedge clk); #1;
            if (mem_read) got_read = 1'b1;
        end
        checks++;
        if (!got_read) begin errors++; $display("FAIL midwalk_read: got mem_read=0 want 1"); end
        #2 rst_n = 1'b0;
        #1;
        outs = {resp_done, resp_fault, resp_accesstag, resp_phys, flush_done, tlb_enable,
                tlb_resolve, tlb_invalidate, tlb_write, tlb_virtual_address,
                tlb_virtual_address_w, tlb_accesstag_w, tlb_phys_w, mem_read, mem_address};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL midwalk_reset_outputs: got %h want 0", outs); end
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; mem_wait = 0;
        @(posedge clk); #1;
        m0 = mem_txn;
        sb.push_back('{fault: 1'b1, tag: 8'h00, phys: 22'h0, lat: 4});
        run_req(20'h02001, lat, seen);
        e = sb.pop_front();
        checks++;
        if ({seen, resp_fault, resp_accesstag, resp_phys, lat} !== {1'b1, e.fault, e.tag, e.phys, e.lat}) begin
            errors++; $display("FAIL midwalk_rewalk: got done=%b f=%b tag=%h phys=%h lat=%0d want f=%b tag=%h phys=%h lat=%0d",
                               seen, resp_fault, resp_accesstag, resp_phys, lat, e.fault, e.tag, e.phys, e.lat);
        end
        @(posedge clk); #1;
        checks++;
        if ((mem_txn - m0) !== 1) begin errors++; $display("FAIL midwalk_mem_count: got %0d want 1", mem_txn - m0); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        maddr[0] = 34'h100004; mdata[0] = 32'h00080401;
        maddr[1] = 34'h201004; mdata[1] = 32'h0123400F;
        maddr[2] = 34'h10000C; mdata[2] = 32'h0040000F;
        maddr[3] = 34'h100010; mdata[3] = 32'h0040040F;
        maddr[4] = 34'h100014; mdata[4] = 32'h00000005;
        maddr[5] = 34'h201008; mdata[5] = 32'h0567800F;
        rst_n = 1'b0; req = 1'b0; req_vpn = '0; flush = 1'b0;
        satp_mode = 1'b0; satp_ppn = '0; tlb_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1 tlb_clr = 1'b0;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_bare();
        test_tlb_hit();
        test_walk();
        test_megapage();
        test_faults();
        test_wait_states();
        test_flush_and_req();
        test_reset_midwalk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
